adc128s_model: RTL and testbench

- Synthesizable behavioural model of an 8-channel, 12-bit ADC128S-style SPI A2D converter, used in the Segway system bench.
- Serves left load cell, right load cell and battery readings to the Segway's A2D interface master over a mode-0 SPI link.
- Each 16-bit frame carries a channel select on MOSI and returns on MISO the conversion of the channel selected in the previous frame.

---
 rtl/adc128s_pkg.sv | 33 +++
 rtl/adc128s_model_if.sv | 14 +
 rtl/spi_sync_edge.sv | 35 +++
 rtl/adc128s_model.sv | 89 ++++++++
 tb/tb_adc128s_model.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/adc128s_pkg.sv
// Shared constants and channel-mapping helper for the ADC128S-style SPI A2D model.
package adc128s_pkg;

    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CH_W       = 3;
    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned ADDR_MSB   = 13;
    localparam int unsigned ADDR_LSB   = 11;

    localparam logic [CH_W-1:0] LFT_CH  = 3'd0;
    localparam logic [CH_W-1:0] RGHT_CH = 3'd4;
    localparam logic [CH_W-1:0] BATT_CH = 3'd5;

    // Conversion result for a channel; unmapped channels read as zero.
    function automatic logic [DATA_W-1:0] ch_value(
        input logic [CH_W-1:0]   ch,
        input logic [DATA_W-1:0] lft,
        input logic [DATA_W-1:0] rght,
        input logic [DATA_W-1:0] batt
    );
        logic [DATA_W-1:0] v;
        v = '0;
        case (ch)
            LFT_CH:  v = lft;
            RGHT_CH: v = rght;
            BATT_CH: v = batt;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/adc128s_model_if.sv
// SPI link between the A2D interface master and the ADC model.
//   SS_n : active-low slave select (master -> slave)
//   SCLK : serial clock, idles low (master -> slave)
//   MOSI : command bits, MSB first (master -> slave)
//   MISO : result bits, MSB first (slave -> master)
interface adc128s_model_if;
    logic SS_n;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output SS_n, output SCLK, output MOSI, input MISO);
    modport slave  (input SS_n, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_sync_edge.sv
// Three-flop synchroniser for an asynchronous SPI control line with
// single-cycle rise/fall pulses derived from the last two stages.
//   clk, rst : system clock, synchronous active-high reset
//   d        : asynchronous input
//   rise_c   : one-cycle pulse on a synchronised 0->1 transition
//   fall_c   : one-cycle pulse on a synchronised 1->0 transition
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise_c,
    output logic fall_c
);

    logic s1, s2, s3;

    // Reset to the idle level so releasing reset produces no spurious edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= RST_VAL;
            s2 <= RST_VAL;
            s3 <= RST_VAL;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise_c = s2 & ~s3;
    assign fall_c = ~s2 & s3;

endmodule

// File: rtl/adc128s_model.sv
// Behavioural model of an 8-channel 12-bit ADC128S-style SPI A2D converter.
// Each 16-bit frame selects a channel via MOSI[13:11]; MISO returns the
// conversion of the channel chosen in the previous complete frame.
//   clk, rst      : system clock, synchronous active-high reset
//   spi           : SPI slave port (SS_n, SCLK, MOSI in; MISO out)
//   lft_cell_set  : value served for LFT_CH
//   rght_cell_set : value served for RGHT_CH
//   batt_set      : value served for BATT_CH
module adc128s_model
    import adc128s_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    adc128s_model_if.slave      spi,
    input  logic [DATA_W-1:0]   lft_cell_set,
    input  logic [DATA_W-1:0]   rght_cell_set,
    input  logic [DATA_W-1:0]   batt_set
);

    logic sclk_rise, sclk_fall;
    logic ss_rise, ss_fall;
    logic mosi_s1, mosi_sync;

    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CH_W-1:0]       cur_ch;
    logic                  in_frame;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi.SCLK),
        .rise_c (sclk_rise),
        .fall_c (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .clk    (clk),
        .rst    (rst),
        .d      (spi.SS_n),
        .rise_c (ss_rise),
        .fall_c (ss_fall)
    );

    // MOSI is only sampled on SCLK rises, so two stages suffice.
    always_ff @(posedge clk) begin
        if (rst) begin
            mosi_s1   <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            mosi_s1   <= spi.MOSI;
            mosi_sync <= mosi_s1;
        end
    end

    // Frame engine: ss_fall outranks any coincident SCLK edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            cur_ch   <= LFT_CH;
            in_frame <= 1'b0;
        end else if (ss_fall) begin
            // Snapshot isolates the outgoing word from *_set changes mid-frame.
            tx_shift <= {4'b0000, ch_value(cur_ch, lft_cell_set, rght_cell_set, batt_set)};
            rx_shift <= '0;
            bit_cnt  <= '0;
            in_frame <= 1'b1;
        end else if (ss_rise) begin
            in_frame <= 1'b0;
            // Only complete frames may change the channel.
            if (bit_cnt == CNT_W'(FRAME_BITS))
                cur_ch <= rx_shift[ADDR_MSB:ADDR_LSB];
        end else if (in_frame) begin
            if (sclk_rise) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_sync};
                if (bit_cnt != CNT_W'(FRAME_BITS))
                    bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (sclk_fall)
                tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
        end
    end

    assign spi.MISO = tx_shift[FRAME_BITS-1];

endmodule

// File: tb/tb_adc128s_model.sv
// Directed self-checking bench for adc128s_model acting as an SPI mode-0 master.
module tb_adc128s_model;
    import adc128s_pkg::*;

    localparam int HALF = 8;   // clk cycles per SCLK half period (SCLK = clk/16)

    logic clk = 1'b0;
    logic rst;
    logic [11:0] lft_cell_set, rght_cell_set, batt_set;
    int errors = 0;
    int checks = 0;

    adc128s_model_if spi_if ();

    adc128s_model dut (
        .clk           (clk),
        .rst           (rst),
        .spi           (spi_if),
        .lft_cell_set  (lft_cell_set),
        .rght_cell_set (rght_cell_set),
        .batt_set      (batt_set)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI frame of nbits, MSB first; optionally rewrites batt_set before bit chg_bit.
    task automatic spi_frame(input logic [31:0] mosi, input int nbits,
                             input int chg_bit, input logic [11:0] chg_val,
                             output logic [31:0] got);
        got = '0;
        spi_if.SS_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_bit) batt_set = chg_val;
            spi_if.MOSI = mosi[nbits-1-i];
            wait_clks(HALF);
            got = {got[30:0], spi_if.MISO};
            spi_if.SCLK = 1'b1;
            wait_clks(HALF);
            spi_if.SCLK = 1'b0;
        end
        wait_clks(HALF);
        spi_if.SS_n = 1'b1;
        spi_if.MOSI = 1'b0;
        wait_clks(HALF);
    endtask

    task automatic frame16(input logic [15:0] mosi, input string name,
                           input logic [15:0] exp);
        logic [31:0] got;
        spi_frame({16'h0, mosi}, 16, -1, 12'h0, got);
        checks++;
        if (got[15:0] !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got[15:0], exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        spi_if.MOSI = 1'b0;
        lft_cell_set = 12'hABC;
        rght_cell_set = 12'h123;
        batt_set = 12'hFFF;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(4);
        checks++;
        if (spi_if.MISO !== 1'b0) begin
            errors++;
            $display("FAIL reset_miso: got %b expected 0", spi_if.MISO);
        end
    endtask

    task automatic test_lft;
        frame16(16'h0000, "lft_first", 16'h0ABC);
        frame16(16'h0000, "lft_again", 16'h0ABC);
    endtask

    task automatic test_channel_switch;
        frame16(16'h2000, "sel_ch4_stale", 16'h0ABC);
        frame16(16'h2800, "read_ch4", 16'h0123);
        frame16(16'h0000, "read_ch5", 16'h0FFF);
    endtask

    task automatic test_unused_ch;
        frame16(16'h3800, "sel_ch7_stale", 16'h0ABC);
        frame16(16'h0000, "read_ch7", 16'h0000);
    endtask

    task automatic test_abort;
        logic [31:0] got;
        frame16(16'h2000, "abort_sel_ch4", 16'h0ABC);
        spi_frame(32'h0000_0028, 8, -1, 12'h0, got);
        frame16(16'h0000, "after_abort", 16'h0123);
    endtask

    task automatic test_snapshot;
        logic [31:0] got;
        batt_set = 12'h800;
        frame16(16'h2800, "snap_sel_ch5", 16'h0ABC);
        spi_frame(32'h0000_2800, 16, 6, 12'h400, got);
        checks++;
        if (got[15:0] !== 16'h0800) begin
            errors++;
            $display("FAIL snap_midframe: got %h expected 0800", got[15:0]);
        end
        frame16(16'h2800, "snap_next", 16'h0400);
    endtask

    task automatic test_extra_edges;
        logic [31:0] got;
        // 20 clocks: leading 4 bits fall off, last 16 select ch4; tx tail is zeros.
        spi_frame(32'h000F_2000, 20, -1, 12'h0, got);
        checks++;
        if (got[19:0] !== 20'h04000) begin
            errors++;
            $display("FAIL extra_edges: got %h expected 04000", got[19:0]);
        end
        frame16(16'h0000, "extra_sel_ch4", 16'h0123);
    endtask

    task automatic test_reset_mid;
        batt_set = 12'hFFF;
        frame16(16'h2800, "rstmid_sel_ch5", 16'h0ABC);
        spi_if.SS_n = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < 6; i++) begin
            wait_clks(HALF);
            spi_if.SCLK = 1'b1;
            wait_clks(HALF);
            spi_if.SCLK = 1'b0;
        end
        wait_clks(HALF);
        checks++;
        if (spi_if.MISO !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got %b expected 1", spi_if.MISO);
        end
        rst = 1'b1;
        wait_clks(2);
        checks++;
        if (spi_if.MISO !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_miso: got %b expected 0", spi_if.MISO);
        end
        spi_if.SS_n = 1'b1;
        spi_if.SCLK = 1'b0;
        wait_clks(4);
        rst = 1'b0;
        wait_clks(HALF);
        frame16(16'h0000, "rstmid_after", 16'h0ABC);
    endtask

    initial begin
        test_reset();
        test_lft();
        test_channel_switch();
        test_unused_ch();
        test_abort();
        test_snapshot();
        test_extra_edges();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
